// File: rtl/osc_indexer.sv
// Oscillator phase indexer: per-voice phase accumulators whose integer part
// addresses the wave table, plus a valid pulse aligned to the wave loader's
// two-cycle registered read of those addresses.
module osc_indexer #(
  parameter int NUM_OSCILLATORS = 4,
  parameter int WW_WIDTH        = 18,
  parameter int FRAC_WIDTH      = 8,
  parameter int INC_WIDTH       = 26
) (
  input  logic                                clk_in,
  input  logic                                rst_in,
  input  logic                                sample_tick_in,
  input  logic [NUM_OSCILLATORS-1:0]          note_on_in,
  input  logic [NUM_OSCILLATORS*INC_WIDTH-1:0] phase_inc_in,
  input  logic [WW_WIDTH-1:0]                 wave_width_in,
  input  logic                                ui_update_trig_in,
  output logic [NUM_OSCILLATORS-1:0]          osc_is_on_out,
  output logic [NUM_OSCILLATORS*WW_WIDTH-1:0] osc_index_out,
  output logic                                sample_valid_out
);

  localparam int PW = WW_WIDTH + FRAC_WIDTH;

  // Phase accumulators, unsigned fixed point with FRAC_WIDTH fraction bits.
  logic [PW-1:0] phase   [NUM_OSCILLATORS];
  // Candidate next phase for a tick, after the wrap rule.
  logic [PW-1:0] wrapped [NUM_OSCILLATORS];
  // Wave length in phase units (wave_width_in << FRAC_WIDTH), one guard bit.
  logic [PW:0]   limit;
  // Tick delayed by three cycles to line up with the wave loader output.
  logic [2:0]    valid_sr;

  assign limit = {1'b0, wave_width_in, {FRAC_WIDTH{1'b0}}};

  genvar g;
  generate
    for (g = 0; g < NUM_OSCILLATORS; g++) begin : g_voice
      logic [PW:0] sum;
      logic [PW:0] diff;

      // Sum carries one extra bit so the comparison against the wave length
      // is exact even when the accumulator plus increment overflows PW bits.
      assign sum  = {1'b0, phase[g]}
                  + {{(PW + 1 - INC_WIDTH){1'b0}}, phase_inc_in[g*INC_WIDTH +: INC_WIDTH]};
      assign diff = sum - limit;

      // One subtraction handles a normal wrap. If the result is still past
      // the end (large increment, or the width shrank under the phase), the
      // voice restarts at 0. A zero width therefore always yields 0.
      assign wrapped[g] = (sum < limit)  ? sum[PW-1:0]  :
                          (diff < limit) ? diff[PW-1:0] : '0;

      assign osc_index_out[g*WW_WIDTH +: WW_WIDTH] = phase[g][PW-1:FRAC_WIDTH];
    end
  endgenerate

  // Gate register, valid delay line and per-voice phase update.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      // NOTE: the phase array is a handful of flops, not a RAM, so it is
      // cleared on reset; otherwise idle voices would expose X indices.
      osc_is_on_out <= '0;
      valid_sr      <= '0;
      for (int i = 0; i < NUM_OSCILLATORS; i++) begin
        phase[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments so every voice sees the same
      // pre-edge osc_is_on_out when detecting a note-on rising edge.
      osc_is_on_out <= note_on_in;
      valid_sr      <= {valid_sr[1:0], sample_tick_in};
      for (int i = 0; i < NUM_OSCILLATORS; i++) begin
        if (ui_update_trig_in) begin
          phase[i] <= '0;
        end else if (note_on_in[i] && !osc_is_on_out[i]) begin
          phase[i] <= '0;
        end else if (sample_tick_in && osc_is_on_out[i]) begin
          phase[i] <= wrapped[i];
        end
      end
    end
  end

  // Reset also masks the pulse combinationally so it is low for the whole
  // reset period, including the first cycle of assertion.
  assign sample_valid_out = valid_sr[2] & ~rst_in;

endmodule
